// File: rtl/mode_select.sv
// mode_select: routes the start strobe and byte of the currently selected
// source channel to a single downstream serializer, with a one-entry
// holding buffer, a sticky drop flag and deferred (idle-only) mode changes.
//
// Ports:
//   sysclk         - system clock, rising edge
//   reset          - synchronous active-high reset
//   data_in        - CHANNELS bytes, channel i at [i*WIDTH +: WIDTH]
//   start_in       - per-channel one-cycle start strobes
//   step           - advance to next mode (wraps)
//   load/load_mode - jump directly to load_mode (ignored if out of range)
//   tx_busy        - serializer busy, high from the cycle after start_out
//   data_out       - registered byte to serializer
//   start_out      - registered one-cycle start to serializer
//   active/LEDs    - one-hot mode and its LED_WIDTH-wide copy
//   mode           - current mode index
//   switch_pending - mode change waiting for the path to go idle
//   overflow       - sticky: a byte was dropped
module mode_select #(
   parameter int CHANNELS  = 3,
   parameter int WIDTH     = 8,
   parameter int LED_WIDTH = 4,
   localparam int MB = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      sysclk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic [CHANNELS-1:0]       start_in,
   input  logic                      step,
   input  logic                      load,
   input  logic [MB-1:0]             load_mode,
   input  logic                      tx_busy,
   output logic [WIDTH-1:0]          data_out,
   output logic                      start_out,
   output logic [CHANNELS-1:0]       active,
   output logic [LED_WIDTH-1:0]      LEDs,
   output logic [MB-1:0]             mode,
   output logic                      switch_pending,
   output logic                      overflow
);

   logic [MB-1:0]        r_mode;
   logic [MB-1:0]        r_target;
   logic                 r_pend;
   logic                 r_start;
   logic [WIDTH-1:0]     r_dout;
   logic                 r_buf_v;
   logic [WIDTH-1:0]     r_buf;
   logic                 r_ovf;
   logic [CHANNELS-1:0]  r_active;
   logic [LED_WIDTH-1:0] r_led;

   logic [WIDTH-1:0]     w_byte;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_idle;
   logic                 w_load_ok;
   logic                 w_req;
   logic [MB-1:0]        w_step_tgt;
   logic [MB-1:0]        w_req_tgt;
   logic [MB-1:0]        w_pend_tgt;
   logic [MB-1:0]        w_mode_nxt;
   logic [CHANNELS-1:0]  w_active_nxt;
   logic [LED_WIDTH-1:0] w_led_nxt;

   always_comb begin
      w_byte     = data_in[r_mode*WIDTH +: WIDTH];
      w_ready    = !tx_busy && !r_start;
      // starts are frozen while a mode change is waiting
      w_accept   = start_in[r_mode] && !r_pend;
      w_idle     = !r_buf_v && w_ready;
      w_load_ok  = load && (load_mode <= MB'(CHANNELS - 1));
      w_req      = !r_pend && (w_load_ok || step);
      w_step_tgt = (r_mode == MB'(CHANNELS - 1)) ? '0 : r_mode + 1'b1;
      w_req_tgt  = w_load_ok ? load_mode : w_step_tgt;
      w_pend_tgt = w_load_ok ? load_mode : r_target;
      w_mode_nxt = r_mode;
      if (w_req && w_idle)
         w_mode_nxt = w_req_tgt;
      else if (r_pend && w_idle)
         w_mode_nxt = w_pend_tgt;
      w_active_nxt = CHANNELS'(1) << w_mode_nxt;
      w_led_nxt    = LED_WIDTH'(32'(w_active_nxt));
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         r_mode   <= '0;
         r_target <= '0;
         r_pend   <= 1'b0;
         r_start  <= 1'b0;
         r_dout   <= '0;
         r_buf_v  <= 1'b0;
         r_buf    <= '0;
         r_ovf    <= 1'b0;
         r_active <= CHANNELS'(1);
         r_led    <= LED_WIDTH'(1);
      end else begin
         r_start <= 1'b0;
         // a held byte always goes first; a new start then refills the buffer
         if (w_ready && r_buf_v) begin
            r_dout  <= r_buf;
            r_start <= 1'b1;
            r_buf_v <= w_accept;
            if (w_accept)
               r_buf <= w_byte;
         end else if (w_ready && w_accept) begin
            r_dout  <= w_byte;
            r_start <= 1'b1;
         end else if (w_accept) begin
            if (!r_buf_v) begin
               r_buf_v <= 1'b1;
               r_buf   <= w_byte;
            end else begin
               r_ovf <= 1'b1;
            end
         end

         r_mode   <= w_mode_nxt;
         r_active <= w_active_nxt;
         r_led    <= w_led_nxt;

         if (r_pend) begin
            if (w_idle)
               r_pend <= 1'b0;
            else if (w_load_ok)
               r_target <= load_mode;
         end else if (w_req && !w_idle) begin
            r_pend   <= 1'b1;
            r_target <= w_req_tgt;
         end
      end
   end

   assign data_out       = r_dout;
   assign start_out      = r_start;
   assign active         = r_active;
   assign LEDs           = r_led;
   assign mode           = r_mode;
   assign switch_pending = r_pend;
   assign overflow       = r_ovf;

endmodule

// File: tb/tb_mode_select.sv
// tb_mode_select: directed vector table, reset sequence and randomized
// run against a queue-based reference model of mode_select.
module tb_mode_select;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] din;
   logic [2:0]  st_in;
   logic        stp;
   logic        ld;
   logic [1:0]  ld_mode;
   logic        busy;
   logic [7:0]  dout;
   logic        so;
   logic [2:0]  act;
   logic [3:0]  leds;
   logic [1:0]  md;
   logic        pend;
   logic        ovf;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mode_select dut (
      .sysclk(clk), .reset(rst), .data_in(din), .start_in(st_in),
      .step(stp), .load(ld), .load_mode(ld_mode), .tx_busy(busy),
      .data_out(dout), .start_out(so), .active(act), .LEDs(leds),
      .mode(md), .switch_pending(pend), .overflow(ovf)
   );

   typedef struct {
      logic       s;
      logic       l;
      logic [1:0] lm;
      logic [2:0] st;
      logic [7:0] b;
      logic       bz;
      int         e_mode;
      logic       e_so;
      logic [7:0] e_d;
      logic       e_ovf;
      logic       e_pend;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic s, input logic l, input logic [1:0] lm,
                      input logic [2:0] st, input logic [7:0] b,
                      input logic bz, input int e_mode, input logic e_so,
                      input logic [7:0] e_d, input logic e_ovf,
                      input logic e_pend);
      vec_t v;
      v = '{s, l, lm, st, b, bz, e_mode, e_so, e_d, e_ovf, e_pend};
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int e_mode,
                          input logic e_so, input logic [7:0] e_d,
                          input logic e_ovf, input logic e_pend);
      logic [31:0] oh;
      oh = 32'd1 << e_mode;
      chk({tag, " mode"}, 32'(md), 32'(e_mode));
      chk({tag, " active"}, 32'(act), oh & 32'h7);
      chk({tag, " LEDs"}, 32'(leds), oh & 32'hF);
      chk({tag, " start_out"}, 32'(so), 32'(e_so));
      chk({tag, " data_out"}, 32'(dout), 32'(e_d));
      chk({tag, " overflow"}, 32'(ovf), 32'(e_ovf));
      chk({tag, " pending"}, 32'(pend), 32'(e_pend));
   endtask

   task automatic drive(input logic r, input logic s, input logic l,
                        input logic [1:0] lm, input logic [2:0] st,
                        input logic [23:0] d, input logic bz);
      rst = r; stp = s; ld = l; ld_mode = lm; st_in = st; din = d; busy = bz;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // reference model state
   int         m_mode, m_pend, m_tgt, m_so, m_ovf;
   logic [7:0] m_dout;
   logic [7:0] q[$];

   task automatic model_reset;
      m_mode = 0; m_pend = 0; m_tgt = 0; m_so = 0; m_ovf = 0;
      m_dout = 8'h00;
      q.delete();
   endtask

   task automatic model_step(input logic r, input logic s, input logic l,
                             input logic [1:0] lm, input logic [2:0] st,
                             input logic [23:0] d, input logic bz);
      bit ready, acc, idle, lok;
      int tgt, n_so;
      logic [7:0] byt;
      if (r) begin
         model_reset();
         return;
      end
      ready = !bz && (m_so == 0);
      acc   = st[m_mode] && (m_pend == 0);
      idle  = (q.size() == 0) && ready;
      byt   = d[m_mode*8 +: 8];
      lok   = l && (int'(lm) < 3);
      n_so  = 0;
      if (ready && q.size() > 0) begin
         m_dout = q.pop_front();
         n_so = 1;
         if (acc) q.push_back(byt);
      end else if (ready && acc) begin
         m_dout = byt;
         n_so = 1;
      end else if (acc) begin
         if (q.size() == 0) q.push_back(byt);
         else m_ovf = 1;
      end
      m_so = n_so;
      if (m_pend == 0) begin
         if (lok || s) begin
            tgt = lok ? int'(lm) : (m_mode + 1) % 3;
            if (idle) m_mode = tgt;
            else begin m_pend = 1; m_tgt = tgt; end
         end
      end else begin
         if (lok) m_tgt = int'(lm);
         if (idle) begin m_mode = m_tgt; m_pend = 0; end
      end
   endtask

   initial begin
      vec_t v;
      logic r, s, l, bz;
      logic [1:0] lm;
      logic [2:0] st;
      logic [23:0] d;

      //  s  l  lm    st      b     bz mode so d     ovf pend
      add(0, 0, 2'd0, 3'b001, 8'h41, 0, 0, 1, 8'h41, 0, 0);
      add(0, 0, 2'd0, 3'b010, 8'h99, 1, 0, 0, 8'h41, 0, 0);
      add(0, 0, 2'd0, 3'b000, 8'h00, 0, 0, 0, 8'h41, 0, 0);
      add(0, 0, 2'd0, 3'b001, 8'h42, 1, 0, 0, 8'h41, 0, 0);
      add(0, 0, 2'd0, 3'b001, 8'h43, 1, 0, 0, 8'h41, 1, 0);
      add(0, 0, 2'd0, 3'b000, 8'h00, 0, 0, 1, 8'h42, 1, 0);
      add(0, 0, 2'd0, 3'b000, 8'h00, 1, 0, 0, 8'h42, 1, 0);
      add(0, 0, 2'd0, 3'b000, 8'h00, 0, 0, 0, 8'h42, 1, 0);
      add(1, 0, 2'd0, 3'b000, 8'h00, 0, 1, 0, 8'h42, 1, 0);
      add(1, 0, 2'd0, 3'b000, 8'h00, 0, 2, 0, 8'h42, 1, 0);
      add(1, 0, 2'd0, 3'b000, 8'h00, 0, 0, 0, 8'h42, 1, 0);
      add(1, 0, 2'd0, 3'b000, 8'h00, 1, 0, 0, 8'h42, 1, 1);
      add(0, 0, 2'd0, 3'b001, 8'h55, 1, 0, 0, 8'h42, 1, 1);
      add(0, 0, 2'd0, 3'b000, 8'h00, 0, 1, 0, 8'h42, 1, 0);
      add(0, 0, 2'd0, 3'b000, 8'h00, 0, 1, 0, 8'h42, 1, 0);
      add(1, 1, 2'd2, 3'b000, 8'h00, 0, 2, 0, 8'h42, 1, 0);
      add(0, 1, 2'd3, 3'b000, 8'h00, 0, 2, 0, 8'h42, 1, 0);
      add(1, 1, 2'd3, 3'b000, 8'h00, 0, 0, 0, 8'h42, 1, 0);
      add(1, 0, 2'd0, 3'b001, 8'h66, 0, 1, 1, 8'h66, 1, 0);
      add(0, 0, 2'd0, 3'b000, 8'h00, 1, 1, 0, 8'h66, 1, 0);
      add(0, 0, 2'd0, 3'b000, 8'h00, 0, 1, 0, 8'h66, 1, 0);
      add(0, 0, 2'd0, 3'b010, 8'hA1, 1, 1, 0, 8'h66, 1, 0);
      add(0, 0, 2'd0, 3'b010, 8'hA2, 0, 1, 1, 8'hA1, 1, 0);
      add(0, 0, 2'd0, 3'b000, 8'h00, 0, 1, 0, 8'hA1, 1, 0);
      add(0, 0, 2'd0, 3'b000, 8'h00, 0, 1, 1, 8'hA2, 1, 0);
      add(0, 0, 2'd0, 3'b000, 8'h00, 0, 1, 0, 8'hA2, 1, 0);
      add(1, 0, 2'd0, 3'b000, 8'h00, 1, 1, 0, 8'hA2, 1, 1);
      add(0, 1, 2'd0, 3'b000, 8'h00, 1, 1, 0, 8'hA2, 1, 1);
      add(1, 0, 2'd0, 3'b000, 8'h00, 1, 1, 0, 8'hA2, 1, 1);
      add(0, 0, 2'd0, 3'b000, 8'h00, 0, 0, 0, 8'hA2, 1, 0);

      drive(1, 0, 0, 2'd0, 3'b000, 24'h0, 0);
      tick();
      tick();
      chk_all("reset", 0, 0, 8'h00, 0, 0);

      foreach (vecs[i]) begin
         v = vecs[i];
         drive(0, v.s, v.l, v.lm, v.st, {3{v.b}}, v.bz);
         tick();
         chk_all($sformatf("row%0d", i), v.e_mode, v.e_so, v.e_d,
                 v.e_ovf, v.e_pend);
      end

      // reset with a full buffer and a pending switch
      drive(0, 0, 0, 2'd0, 3'b001, {3{8'hC3}}, 1);
      tick();
      drive(0, 1, 0, 2'd0, 3'b000, 24'h0, 1);
      tick();
      chk("pre-reset pending", 32'(pend), 32'd1);
      drive(1, 1, 1, 2'd2, 3'b001, {3{8'hC4}}, 1);
      tick();
      chk_all("rst-mid", 0, 0, 8'h00, 0, 0);
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 0, 2'd0, 3'b000, 24'h0, 0);
         tick();
         chk_all($sformatf("post-rst%0d", k), 0, 0, 8'h00, 0, 0);
      end

      // randomized run against the reference model
      drive(1, 0, 0, 2'd0, 3'b000, 24'h0, 0);
      tick();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         r  = ($urandom_range(0, 199) == 0);
         s  = ($urandom_range(0, 99) < 10);
         l  = ($urandom_range(0, 99) < 8);
         lm = 2'($urandom_range(0, 3));
         st = 3'($urandom_range(0, 7));
         d  = 24'($urandom);
         bz = ($urandom_range(0, 99) < 40);
         drive(r, s, l, lm, st, d, bz);
         model_step(r, s, l, lm, st, d, bz);
         tick();
         chk_all($sformatf("rnd%0d", c), m_mode, 1'(m_so), m_dout,
                 1'(m_ovf), 1'(m_pend));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mode_select.md
MODE_SELECT -- requirements
Module: mode_select

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, number of source channels (legal 2..8).
REQ-002 SHALL have parameter WIDTH, default 8, data byte width per channel.
REQ-003 SHALL have parameter LED_WIDTH, default 4, width of LED indicator bus.
REQ-004 SHALL derive MB = max(1, clog2(CHANNELS)), mode index width.
REQ-005 SHALL have one clock and a synchronous, active-high reset, named as follows.
REQ-006 sysclk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 data_in  input  CHANNELS*WIDTH  flattened source bytes; channel i at bits [i*WIDTH +: WIDTH].
REQ-009 start_in  input  CHANNELS  per-channel single-cycle start strobe.
REQ-010 step  input  1  advance-mode pulse, already debounced, one cycle.
REQ-011 load  input  1  direct mode-load pulse.
REQ-012 load_mode  input  MB  target mode for load.
REQ-013 tx_busy  input  1  downstream serializer busy; asserted from cycle after start_out.
REQ-014 data_out  output  WIDTH  byte to serializer, registered.
REQ-015 start_out  output  1  single-cycle start to serializer, registered.
REQ-016 active  output  CHANNELS  one-hot current mode.
REQ-017 LEDs  output  LED_WIDTH  mode indicator.
REQ-018 mode  output  MB  current mode index.
REQ-019 switch_pending  output  1  mode change requested, not yet committed.
REQ-020 overflow  output  1  sticky byte-drop flag.

Function
REQ-021 SHALL accept start_in only on the channel equal to mode; other strobes ignored.
REQ-022 SHALL define issue-ready = !tx_busy && !start_out.
REQ-023 On accepted start with issue-ready and buffer empty, SHALL load data_out with that channel's byte and pulse start_out next cycle (latency 1).
REQ-024 On accepted start when not issue-ready or buffer full-draining, SHALL store byte in a one-entry buffer if empty.
REQ-025 Buffered byte SHALL issue on first issue-ready cycle; buffer empty same edge; buffer has priority over new start, new start then goes to buffer.
REQ-026 Accepted start while buffer full and not draining SHALL be dropped and set overflow, held until reset.
REQ-027 start_out SHALL never assert on two consecutive cycles; data_out SHALL hold value between issues.
REQ-028 step SHALL request target = (mode+1) wrapping CHANNELS-1 -> 0.
REQ-029 load SHALL request target = load_mode; load_mode >= CHANNELS SHALL be ignored entirely.
REQ-030 step and load same cycle: load wins (step wins only if load_mode illegal).
REQ-031 Switch SHALL commit when idle: buffer empty, tx_busy=0, start_out=0; idle at request -> mode updates next edge, switch_pending stays 0.
REQ-032 Not idle at request: switch_pending=1, target latched; commit on first idle cycle, switch_pending clears same edge.
REQ-033 While switch_pending: step ignored; legal load overwrites target; all start_in ignored.
REQ-034 Start in same cycle as a committing request SHALL be evaluated against old mode.
REQ-035 active SHALL equal one-hot of mode; LEDs = active zero-extended or truncated to LED_WIDTH; both registered alongside mode.

Reset
REQ-036 On reset: mode=0, active=1, LEDs=1, data_out=0, start_out=0, buffer empty, switch_pending=0, overflow=0, target=0.
REQ-037 Reset mid-transfer or mid-pending SHALL discard buffer and pending switch; takes priority over all inputs.

Verification
REQ-038 Defaults, idle: start_in[0] with byte 0x41 -> data_out=0x41, start_out pulse 1 cycle later; start_in[1] ignored.
REQ-039 tx_busy=1, start_in[0]=0x42 then 0x43 -> 0x42 buffered, 0x43 dropped, overflow=1; tx_busy falls -> 0x42 issued.
REQ-040 step x3 while idle -> mode 1,2,0; LEDs 0b0010, 0b0100, 0b0001.
REQ-041 step while tx_busy=1 -> switch_pending=1, start_in[0] ignored, mode commits the cycle after tx_busy=0, pending cleared.
REQ-042 load_mode=2 with step same cycle -> mode=2; load_mode=3 (CHANNELS=3) -> no change.
REQ-043 reset asserted with buffer full and pending switch -> all outputs to reset values next edge.
